// File: rtl/c3po_reg_bridge.sv
// Command-to-register bridge for the C-3PO register block.
// One command in flight: decode, drive req until ack or timeout, return status.
module c3po_reg_bridge #(
  parameter int PORTS_P       = 4,
  parameter int ADDR_OFFSET_P = 10,
  parameter int ADDR_SIZE_P   = 6,
  parameter int TIMEOUT_P     = 16
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_SIZE_P-1:0] cmd_addr,
  input  logic                   cmd_rd_wr,
  input  logic [31:0]            cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_rdata,
  output logic [1:0]             rsp_err,
  output logic                   req,
  output logic [ADDR_SIZE_P-1:0] addr,
  output logic                   rd_wr,
  output logic [31:0]            write_val,
  input  logic [31:0]            read_val,
  input  logic                   ack,
  output logic [7:0]             err_count
);

  localparam int CW = (TIMEOUT_P > 1) ? $clog2(TIMEOUT_P) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_P - 1);

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_DEC = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t                 state, state_n;
  logic                   req_n;
  logic [ADDR_SIZE_P-1:0] addr_n;
  logic                   rd_wr_n;
  logic [31:0]            wval_n;
  logic [31:0]            rdata_n;
  logic [1:0]             err_n;
  logic [7:0]             ecnt_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic                   hit;

  // Compare at 32 bits so a slice base beyond the address range never aliases.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < PORTS_P; i++) begin
      if (32'(cmd_addr) == 32'(ADDR_OFFSET_P * i))
        hit = 1'b1;
    end
  end

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_n = state;
    req_n   = req;
    addr_n  = addr;
    rd_wr_n = rd_wr;
    wval_n  = write_val;
    rdata_n = rsp_rdata;
    err_n   = rsp_err;
    ecnt_n  = err_count;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_n  = cmd_addr;
          rd_wr_n = cmd_rd_wr;
          wval_n  = cmd_wdata;
          if (hit) begin
            state_n = ISSUE;
            req_n   = 1'b1;
            cnt_n   = '0;
          end else begin
            state_n = RESP;
            rdata_n = '0;
            err_n   = ERR_DEC;
            if (err_count != 8'hFF)
              ecnt_n = err_count + 8'd1;
          end
        end
      end
      ISSUE: begin
        if (ack) begin
          state_n = RESP;
          req_n   = 1'b0;
          rdata_n = rd_wr ? 32'd0 : read_val;
          err_n   = ERR_OK;
        end else if (cnt == CNT_LAST) begin
          state_n = RESP;
          req_n   = 1'b0;
          rdata_n = '0;
          err_n   = ERR_TMO;
          if (err_count != 8'hFF)
            ecnt_n = err_count + 8'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state     <= IDLE;
      req       <= 1'b0;
      addr      <= '0;
      rd_wr     <= 1'b0;
      write_val <= '0;
      rsp_rdata <= '0;
      rsp_err   <= ERR_OK;
      err_count <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      req       <= req_n;
      addr      <= addr_n;
      rd_wr     <= rd_wr_n;
      write_val <= wval_n;
      rsp_rdata <= rdata_n;
      rsp_err   <= err_n;
      err_count <= ecnt_n;
      cnt       <= cnt_n;
    end
  end

endmodule

// File: tb/tb_c3po_reg_bridge.sv
// Directed bench for c3po_reg_bridge: reads, writes, decode errors,
// timeout boundary, backpressure, counter saturation and mid-op reset.
module tb_c3po_reg_bridge;

  logic        clk = 1'b0;
  logic        reset_L;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_addr;
  logic        cmd_rd_wr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        req;
  logic [5:0]  addr;
  logic        rd_wr;
  logic [31:0] write_val;
  logic [31:0] read_val;
  logic        ack;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  c3po_reg_bridge dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_rd_wr (cmd_rd_wr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .req       (req),
    .addr      (addr),
    .rd_wr     (rd_wr),
    .write_val (write_val),
    .read_val  (read_val),
    .ack       (ack),
    .err_count (err_count)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [5:0] a, input logic rw,
                      input logic [31:0] wd);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_rd_wr = rw;
    cmd_wdata = wd;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset_L   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_rd_wr = 1'b0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    read_val  = '0;
    ack       = 1'b0;
    cyc();
    cyc();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 0);
    chk("rst_write_val", write_val, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_err_count", err_count, 0);
    reset_L = 1'b1;
    cyc();

    // read, ack in the first req cycle
    send(6'd10, 1'b0, 32'hDEAD_BEEF);
    chk("rd_req", req, 1);
    chk("rd_addr", addr, 10);
    chk("rd_rd_wr", rd_wr, 0);
    chk("rd_no_rsp", rsp_valid, 0);
    ack      = 1'b1;
    read_val = 32'h0000_0005;
    cyc();
    ack = 1'b0;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_req_drop", req, 0);
    chk("rd_rdata", rsp_rdata, 32'h5);
    chk("rd_err", rsp_err, 0);
    take();
    chk("rd_rsp_drop", rsp_valid, 0);
    chk("rd_cmd_ready", cmd_ready, 1);

    // write, ack on the fourth req cycle
    send(6'd20, 1'b1, 32'hA5A5_0003);
    for (int k = 0; k < 4; k++) begin
      chk("wr_req", req, 1);
      chk("wr_wval", write_val, 32'hA5A5_0003);
      chk("wr_rd_wr", rd_wr, 1);
      if (k == 3) begin
        ack      = 1'b1;
        read_val = 32'h7777_7777;
      end
      cyc();
    end
    ack = 1'b0;
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rdata", rsp_rdata, 0);
    chk("wr_err", rsp_err, 0);
    chk("wr_req_drop", req, 0);
    take();

    // decode errors
    send(6'd11, 1'b0, 32'h0);
    chk("dec1_req", req, 0);
    chk("dec1_rsp_valid", rsp_valid, 1);
    chk("dec1_err", rsp_err, 1);
    chk("dec1_rdata", rsp_rdata, 0);
    chk("dec1_count", err_count, 1);
    take();
    send(6'd40, 1'b1, 32'h1234);
    chk("dec2_req", req, 0);
    chk("dec2_rsp_valid", rsp_valid, 1);
    chk("dec2_err", rsp_err, 1);
    chk("dec2_count", err_count, 2);
    take();

    // timeout: no ack for 16 cycles
    send(6'd0, 1'b0, 32'h0);
    for (int k = 0; k < 16; k++) begin
      chk("tmo_req_high", req, 1);
      chk("tmo_no_rsp", rsp_valid, 0);
      cyc();
    end
    chk("tmo_req_low", req, 0);
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_err", rsp_err, 2);
    chk("tmo_rdata", rsp_rdata, 0);
    chk("tmo_count", err_count, 3);
    ack      = 1'b1;
    read_val = 32'hFFFF_FFFF;
    cyc();
    ack = 1'b0;
    chk("late_ack_valid", rsp_valid, 1);
    chk("late_ack_rdata", rsp_rdata, 0);
    chk("late_ack_err", rsp_err, 2);
    chk("late_ack_count", err_count, 3);
    chk("late_ack_req", req, 0);
    take();

    // ack on the last allowed cycle wins
    send(6'd30, 1'b0, 32'h0);
    for (int k = 0; k < 16; k++) begin
      chk("edge_req_high", req, 1);
      if (k == 15) begin
        ack      = 1'b1;
        read_val = 32'h0000_1234;
      end
      cyc();
    end
    ack = 1'b0;
    chk("edge_rsp_valid", rsp_valid, 1);
    chk("edge_err", rsp_err, 0);
    chk("edge_rdata", rsp_rdata, 32'h1234);
    chk("edge_count", err_count, 3);
    take();

    // backpressure
    send(6'd11, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_err", rsp_err, 1);
      chk("bp_rdata", rsp_rdata, 0);
      chk("bp_cmd_ready", cmd_ready, 0);
      cyc();
    end
    chk("bp_count", err_count, 4);
    take();
    chk("bp_released", cmd_ready, 1);

    // saturation
    for (int k = 0; k < 300; k++) begin
      send(6'd11, 1'b0, 32'h0);
      take();
    end
    chk("sat_count", err_count, 255);

    // reset during ISSUE
    send(6'd10, 1'b0, 32'h0);
    chk("mrst_req_before", req, 1);
    reset_L = 1'b0;
    cyc();
    reset_L = 1'b1;
    chk("mrst_req", req, 0);
    chk("mrst_cmd_ready", cmd_ready, 1);
    chk("mrst_count", err_count, 0);
    chk("mrst_rsp_valid", rsp_valid, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("mrst_quiet", rsp_valid, 0);
      chk("mrst_req_low", req, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
